frame_loader_ctrl: RTL

- Per-column configuration sequencer that sits between the bitstream word stream and a tile column's frame-latch configuration memories.
- Accepts header/data word pairs over a valid/ready stream and decodes the target frame index.
- Drives FrameData and a one-hot FrameStrobe with programmable setup, strobe-width and hold timing, so the level-sensitive latches capture cleanly.
- Also reports busy/done, a sticky protocol error and a count of frames written.

---
 rtl/frame_loader_ctrl_if.sv | 11 +
 rtl/frame_loader_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/frame_loader_ctrl_if.sv
// Word stream from the bitstream source into a column frame loader.
interface frame_loader_ctrl_if #(
    parameter int Width = 32
);
    logic [Width-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_loader_ctrl.sv
// Column frame loader: decodes header/data word pairs and drives one frame
// latch strobe with programmable setup, strobe-width and hold timing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a header word
// WAIT_DATA | header decoded, waiting for the frame data word
// DISCARD   | out-of-range header seen, swallow the following word
// SETUP     | FrameData stable, strobe still low
// STROBE    | FrameStrobe[index] high
// HOLD      | strobe low, FrameData held before returning to IDLE
module frame_loader_ctrl #(
    parameter int MaxFramesPerCol = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    frame_loader_ctrl_if.slave         stream,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       err_clear,
    output logic [15:0]                frame_count
);
    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, DISCARD, SETUP, STROBE, HOLD
    } state_t;

    localparam logic [3:0] SetupLast  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HoldLast   = 4'(HOLD_CYCLES - 1);

    state_t state, nextState;
    logic [7:0] frameIdx;
    logic [3:0] timer;
    logic accept, markerOk, idxInRange, timedState;
    logic loadIdx, loadData, setErr, timerClr, strobeOn, strobeOff, frameDone;
    logic [MaxFramesPerCol-1:0] oneHot;

    assign stream.s_ready = ~RST & ((state == IDLE) | (state == WAIT_DATA) | (state == DISCARD));
    assign accept     = stream.s_valid & stream.s_ready;
    assign markerOk   = (stream.s_data[31:24] == 8'hFA);
    assign idxInRange = ({24'd0, stream.s_data[7:0]} < 32'(MaxFramesPerCol));
    assign timedState = (state == SETUP) | (state == STROBE) | (state == HOLD);
    assign busy       = (state != IDLE);
    assign oneHot     = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << frameIdx;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadIdx   = 1'b0;
        loadData  = 1'b0;
        setErr    = 1'b0;
        timerClr  = 1'b0;
        strobeOn  = 1'b0;
        strobeOff = 1'b0;
        frameDone = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!markerOk) begin
                        setErr = 1'b1;
                    end else if (idxInRange) begin
                        loadIdx   = 1'b1;
                        nextState = WAIT_DATA;
                    end else begin
                        setErr    = 1'b1;
                        nextState = DISCARD;
                    end
                end
            end
            WAIT_DATA: begin
                if (accept) begin
                    loadData  = 1'b1;
                    timerClr  = 1'b1;
                    nextState = SETUP;
                end
            end
            DISCARD: begin
                if (accept) nextState = IDLE;
            end
            SETUP: begin
                if (timer == SetupLast) begin
                    strobeOn  = 1'b1;
                    timerClr  = 1'b1;
                    nextState = STROBE;
                end
            end
            STROBE: begin
                if (timer == StrobeLast) begin
                    strobeOff = 1'b1;
                    timerClr  = 1'b1;
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (timer == HoldLast) begin
                    frameDone = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            FrameData   <= '0;
            FrameStrobe <= '0;
            frameIdx    <= '0;
            timer       <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= frameDone;
            if (loadIdx)  frameIdx  <= stream.s_data[7:0];
            if (loadData) FrameData <= stream.s_data;
            if (strobeOn)       FrameStrobe <= oneHot;
            else if (strobeOff) FrameStrobe <= '0;
            timer <= (timerClr || !timedState) ? 4'd0 : timer + 4'd1;
            // a new error event outranks a simultaneous clear
            if (setErr)         err <= 1'b1;
            else if (err_clear) err <= 1'b0;
            if (frameDone && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
        end
    end
endmodule
